eth_pkt_generator: RTL
======================

Name: eth_pkt_generator

Overview:
- Test-traffic source on the transmit side of a vertical NAP Ethernet path.
- Drives a t_ETH_STREAM.tx stream with sequenced packets that a downstream checker can verify: sop/eop framing, mod, incrementing-byte payload and SOP timestamp.
- Sits directly upstream of the NAP Ethernet wrapper; its stream connects to the wrapper's transmit (NAP-receive) port.

Parameters:
- NUM_PKTS, 0: packets per run; 0 = continuous until i_stop.
- PKT_LEN_MIN, 64: minimum packet length in bytes; range 1..16383.
- PKT_LEN_MAX, 1518: maximum packet length in bytes; must be >= PKT_LEN_MIN.
- IFG_CYCLES, 2: idle cycles inserted after each eop beat is accepted; 0 allowed.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- i_start  in  1  one-cycle pulse; begins a run.
- i_stop  in  1  one-cycle pulse; ends the run after the current packet.
- if_eth_tx  t_ETH_STREAM.tx  -  stream to the NAP wrapper: valid, ready, sop, eop, data[255:0], mod[4:0], flags, timestamp[29:0].
- o_busy  out  1  high while a run is active.
- o_done  out  1  high after NUM_PKTS packets sent; cleared by i_start.
- o_pkt_count  out  32  packets completed (eop accepted) in the current run.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_reset_n is asynchronous and active-low.
- Reset values: valid, sop, eop, data, mod, flags and timestamp = 0; o_busy = 0; o_done = 0; o_pkt_count = 0; FSM = IDLE; length register = PKT_LEN_MIN; seq = 0; timestamp counter = 0.
- Reset mid-packet: the packet is abandoned and all outputs clear immediately; no partial packet resumes.
- Timestamp counter: 30-bit, free-running, increments every cycle, wraps 2^30-1 -> 0.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE: on i_start, clear o_pkt_count and o_done, set o_busy, go to SEND. The first beat is presented the cycle after i_start.
- SEND: beats per packet = ceil(len/32).
  - valid is held high; all beat fields stay stable until ready is sampled high.
  - A beat transfers on the cycle where valid & ready are both high.
  - A single-beat packet drives sop and eop together.
  - On the eop transfer: o_pkt_count++, seq++, len steps (see below). Next state is GAP if IFG_CYCLES > 0, otherwise SEND; the next packet's sop may then follow in the very next cycle.
- GAP: valid low for exactly IFG_CYCLES cycles, then SEND.
- Run end:
  - NUM_PKTS != 0 and o_pkt_count reaches NUM_PKTS on an eop transfer: go to DONE. o_done = 1, o_busy = 0.
  - i_stop seen at any time during a run (latched): finish the current packet, then go to IDLE with o_busy = 0 and o_done = 0.
  - If stop and NUM_PKTS completion coincide on the same eop, DONE wins.
- DONE: stays until i_start, which behaves as in IDLE.
- i_start while o_busy is ignored. i_stop in IDLE or DONE is ignored.
- Length sequence: len advances by 1 per packet; after PKT_LEN_MAX it wraps to PKT_LEN_MIN.
- Payload:
  - Byte k of a packet (k = 0 first) = (seq[7:0] + k) mod 256.
  - Within a beat, the byte with the lowest k is in data[7:0].
  - Unused bytes of the last beat = 0.
- mod: 0 on non-eop beats. On the eop beat, mod = (32 - len mod 32) mod 32, i.e. the number of unused bytes; 0 means all 32 bytes are valid.
- timestamp: on the sop beat, carries the counter value captured when that beat was first presented. Held through ready stalls, not resampled. 0 on all other beats.
- flags: all-zero on every beat, including the sop beat.
- Data path is registered; no combinational path from ready to valid or data.

Test Plan:
- Basic run: NUM_PKTS=3, LEN_MIN=LEN_MAX=64, ready=1 -> 3 packets of 2 beats each; mod=0; beat0 of packet0 data[7:0]=0x00; packet1 byte0=0x01; o_done=1; o_pkt_count=3.
- Mod and single beat: LEN_MIN=1, LEN_MAX=33 -> len 1 gives sop=eop=1, mod=31; len 32 gives mod=0 on 1 beat; len 33 gives 2 beats, mod=31; the next packet has len 1.
- Backpressure: toggle ready pseudo-randomly at 50% -> no beat lost or duplicated; fields stable while valid & !ready; sop timestamp unchanged across stalls.
- Gap: IFG_CYCLES=0, ready=1 -> the sop of packet n+1 is in the cycle after the eop of packet n. IFG_CYCLES=3 -> exactly 3 valid-low cycles between them.
- Stop: NUM_PKTS=0, i_stop pulse during beat 2 of a 10-beat packet -> all 10 beats complete, then IDLE; o_busy=0; o_done=0.
- Async reset mid-packet -> valid=0 and o_pkt_count=0 with no clock edge. A following i_start begins at seq 0, len PKT_LEN_MIN.

Source files
------------

// File: rtl/eth_pkt_generator.sv
// Test-traffic source for the NAP Ethernet transmit path: sequenced packets with
// incrementing-byte payload, end-of-packet byte count (mod) and a SOP timestamp.
//   state | meaning
//   IDLE  | no run active, waiting for i_start
//   SEND  | presenting packet beats, advancing on valid & ready
//   GAP   | inter-frame idle cycles after an accepted eop
//   DONE  | NUM_PKTS packets sent, waiting for i_start
module eth_pkt_generator #(
  parameter int NUM_PKTS    = 0,
  parameter int PKT_LEN_MIN = 64,
  parameter int PKT_LEN_MAX = 1518,
  parameter int IFG_CYCLES  = 2
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_start,
  input  logic         i_stop,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  output logic         o_tx_sop,
  output logic         o_tx_eop,
  output logic [255:0] o_tx_data,
  output logic [4:0]   o_tx_mod,
  output logic [3:0]   o_tx_flags,
  output logic [29:0]  o_tx_timestamp,
  output logic         o_busy,
  output logic         o_done,
  output logic [31:0]  o_pkt_count
);

  localparam logic [13:0] LEN_MIN  = 14'(PKT_LEN_MIN);
  localparam logic [13:0] LEN_MAX  = 14'(PKT_LEN_MAX);
  localparam logic [15:0] GAP_LOAD = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t        state_q;
  logic          valid_q, sop_q, eop_q, busy_q, done_q, stop_q;
  logic [255:0]  data_q;
  logic [4:0]    mod_q;
  logic [29:0]   ts_out_q, ts_q;
  logic [31:0]   cnt_q;
  logic [13:0]   len_q, off_q;
  logic [7:0]    seq_q;
  logic [15:0]   gap_q;

  logic          xfer, stop_hit, done_hit;
  logic [31:0]   cnt_d;
  logic [13:0]   len_d, off_d;
  logic [7:0]    seq_d;
  logic [255:0]  cur_data, nxt_data, nb_data;
  logic          cur_eop, nxt_eop, nb_eop;
  logic [4:0]    cur_mod, nxt_mod, nb_mod;

  // Lane j of a beat starting at byte offset off carries byte (seq + off + j), or 0 past len.
  function automatic logic [255:0] beat_data(input logic [7:0] seq, input logic [13:0] off,
                                             input logic [13:0] len);
    logic [255:0] d;
    d = '0;
    for (int j = 0; j < 32; j++) begin
      if (({1'b0, off} + 15'(j)) < {1'b0, len}) d[8*j +: 8] = seq + off[7:0] + 8'(j);
    end
    return d;
  endfunction

  function automatic logic beat_eop(input logic [13:0] off, input logic [13:0] len);
    return ({1'b0, off} + 15'd32) >= {1'b0, len};
  endfunction

  function automatic logic [4:0] beat_mod(input logic [13:0] off, input logic [13:0] len);
    logic [14:0] r;
    r = {1'b0, len} - {1'b0, off};
    if (beat_eop(off, len)) return 5'(6'd32 - r[5:0]);
    return 5'd0;
  endfunction

  always_comb begin
    xfer     = valid_q & i_tx_ready;
    stop_hit = stop_q | i_stop;
    cnt_d    = cnt_q + 32'd1;
    done_hit = (NUM_PKTS != 0) && (cnt_d == 32'(NUM_PKTS));
    len_d    = (len_q >= LEN_MAX) ? LEN_MIN : len_q + 14'd1;
    seq_d    = seq_q + 8'd1;
    off_d    = off_q + 14'd32;
    cur_data = beat_data(seq_q, 14'd0, len_q);
    cur_eop  = beat_eop(14'd0, len_q);
    cur_mod  = beat_mod(14'd0, len_q);
    nxt_data = beat_data(seq_d, 14'd0, len_d);
    nxt_eop  = beat_eop(14'd0, len_d);
    nxt_mod  = beat_mod(14'd0, len_d);
    nb_data  = beat_data(seq_q, off_d, len_q);
    nb_eop   = beat_eop(off_d, len_q);
    nb_mod   = beat_mod(off_d, len_q);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      data_q   <= '0;
      mod_q    <= '0;
      ts_out_q <= '0;
      ts_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stop_q   <= 1'b0;
      cnt_q    <= '0;
      len_q    <= LEN_MIN;
      off_q    <= '0;
      seq_q    <= '0;
      gap_q    <= '0;
    end else begin
      ts_q <= ts_q + 30'd1;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state_q  <= S_SEND;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            stop_q   <= 1'b0;
            off_q    <= '0;
            valid_q  <= 1'b1;
            sop_q    <= 1'b1;
            eop_q    <= cur_eop;
            data_q   <= cur_data;
            mod_q    <= cur_mod;
            ts_out_q <= ts_q + 30'd1;
          end
        end
        S_SEND: begin
          if (i_stop) stop_q <= 1'b1;
          if (xfer && eop_q) begin
            cnt_q <= cnt_d;
            seq_q <= seq_d;
            len_q <= len_d;
            // Stop and completion on the same eop: completion takes priority.
            if (done_hit || stop_hit || IFG_CYCLES > 0) begin
              valid_q  <= 1'b0;
              sop_q    <= 1'b0;
              eop_q    <= 1'b0;
              data_q   <= '0;
              mod_q    <= '0;
              ts_out_q <= '0;
              if (done_hit) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else if (stop_hit) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_GAP;
                gap_q   <= GAP_LOAD;
              end
            end else begin
              off_q    <= '0;
              sop_q    <= 1'b1;
              eop_q    <= nxt_eop;
              data_q   <= nxt_data;
              mod_q    <= nxt_mod;
              ts_out_q <= ts_q + 30'd1;
            end
          end else if (xfer) begin
            off_q    <= off_d;
            sop_q    <= 1'b0;
            eop_q    <= nb_eop;
            data_q   <= nb_data;
            mod_q    <= nb_mod;
            ts_out_q <= '0;
          end
        end
        S_GAP: begin
          if (stop_hit) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (gap_q == 16'd0) begin
            state_q  <= S_SEND;
            off_q    <= '0;
            valid_q  <= 1'b1;
            sop_q    <= 1'b1;
            eop_q    <= cur_eop;
            data_q   <= cur_data;
            mod_q    <= cur_mod;
            ts_out_q <= ts_q + 30'd1;
          end else begin
            gap_q <= gap_q - 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_tx_valid     = valid_q;
  assign o_tx_sop       = sop_q;
  assign o_tx_eop       = eop_q;
  assign o_tx_data      = data_q;
  assign o_tx_mod       = mod_q;
  assign o_tx_flags     = '0;
  assign o_tx_timestamp = ts_out_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_pkt_count    = cnt_q;

endmodule
